// File: rtl/acq_sched_pkg.sv
// Shared types, widths and the configuration check for the ADC acquisition
// echo scheduler.
package acq_sched_pkg;

  localparam int ACQ_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ECHO = 2'd2
  } sched_state_e;

  // Offset+length is summed one bit wider so huge offsets cannot wrap into range.
  function automatic logic cfg_valid(
    input logic [ACQ_DW-1:0] ec,
    input logic [ACQ_DW-1:0] len,
    input logic [ACQ_DW-1:0] off,
    input logic [ACQ_DW-1:0] per
  );
    logic [ACQ_DW:0] span;
    span = {1'b0, off} + {1'b0, len};
    return (ec != {ACQ_DW{1'b0}}) && (len != {ACQ_DW{1'b0}}) && (span < {1'b0, per});
  endfunction

endpackage

// File: rtl/acq_period_cnt.sv
// Loadable up-counter with terminal-count flag and a window compare evaluated
// on the value the counter takes at the next edge.
module acq_period_cnt
  import acq_sched_pkg::*;
#(
  parameter int W = ACQ_DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  input  logic [W-1:0] off,
  input  logic [W-1:0] len,
  output logic         tc,
  output logic         win_next
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] nxt_s;
  logic [W:0]   win_end_s;

  // Next count and lookahead window compare against [off, off+len).
  always_comb begin
    nxt_s     = cnt_r;
    win_end_s = {1'b0, off} + {1'b0, len};
    if (clear) begin
      nxt_s = {W{1'b0}};
    end else if (load) begin
      nxt_s = load_val;
    end else if (en) begin
      nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      nxt_s = cnt_r;
    end
    tc       = (cnt_r == term);
    win_next = ({1'b0, nxt_s} >= {1'b0, off}) && ({1'b0, nxt_s} < win_end_s);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= nxt_s;
    end
  end

endmodule

// File: rtl/acq_echo_scheduler.sv
// Sequences ECHO_COUNT acquisition windows across a CPMG echo train, one train
// per accepted START, with abort, completion and configuration-error reporting.
module acq_echo_scheduler
  import acq_sched_pkg::*;
#(
  parameter int DATABUS_WIDTH = ACQ_DW
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [DATABUS_WIDTH-1:0] PRE_DELAY,
  input  logic [DATABUS_WIDTH-1:0] ECHO_PERIOD,
  input  logic [DATABUS_WIDTH-1:0] WND_OFFSET,
  input  logic [DATABUS_WIDTH-1:0] WND_LENGTH,
  input  logic [DATABUS_WIDTH-1:0] ECHO_COUNT,
  output logic                     ACQ_WND,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [DATABUS_WIDTH-1:0] ECHO_IDX
);

  localparam logic [DATABUS_WIDTH-1:0] ZERO = {DATABUS_WIDTH{1'b0}};
  localparam logic [DATABUS_WIDTH-1:0] ONE  = {{(DATABUS_WIDTH-1){1'b0}}, 1'b1};

  sched_state_e state_r, state_nxt_s;
  logic [DATABUS_WIDTH-1:0] pd_r, ep_r, off_r, len_r, ec_r, idx_r, idx_nxt_s, term_s;
  logic acq_r, busy_r, done_r, err_r;
  logic acq_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
  logic cfg_ok_s, latch_s, cnt_clear_s, cnt_load_s, cnt_en_s, tc_s, win_next_s;

  assign cfg_ok_s = cfg_valid(ECHO_COUNT, WND_LENGTH, WND_OFFSET, ECHO_PERIOD);
  assign term_s   = (state_r == PRE) ? (pd_r - ONE) : (ep_r - ONE);

  acq_period_cnt #(.W(DATABUS_WIDTH)) u_period_cnt (
    .clk      (CLK),
    .rst_n    (RESET),
    .clear    (cnt_clear_s),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (ZERO),
    .term     (term_s),
    .off      (off_r),
    .len      (len_r),
    .tc       (tc_s),
    .win_next (win_next_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next output values; acceptance uses the raw config inputs.
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = busy_r;
    idx_nxt_s   = idx_r;
    acq_nxt_s   = 1'b0;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    latch_s     = 1'b0;
    cnt_clear_s = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    if (ABORT) begin
      state_nxt_s = IDLE;
      busy_nxt_s  = 1'b0;
      idx_nxt_s   = ZERO;
      cnt_clear_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_clear_s = 1'b1;
          if (START && cfg_ok_s) begin
            latch_s     = 1'b1;
            busy_nxt_s  = 1'b1;
            idx_nxt_s   = ZERO;
            acq_nxt_s   = (PRE_DELAY == ZERO) && (WND_OFFSET == ZERO);
            state_nxt_s = (PRE_DELAY == ZERO) ? ECHO : PRE;
          end else begin
            err_nxt_s   = START;
            state_nxt_s = IDLE;
          end
        end
        PRE: begin
          cnt_en_s = 1'b1;
          if (tc_s) begin
            cnt_load_s  = 1'b1;
            state_nxt_s = ECHO;
            acq_nxt_s   = win_next_s;
          end else begin
            acq_nxt_s = 1'b0;
          end
        end
        ECHO: begin
          cnt_en_s = 1'b1;
          if (tc_s && (idx_r == ec_r - ONE)) begin
            cnt_clear_s = 1'b1;
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            idx_nxt_s   = ZERO;
          end else if (tc_s) begin
            cnt_load_s = 1'b1;
            idx_nxt_s  = idx_r + ONE;
            acq_nxt_s  = win_next_s;
          end else begin
            acq_nxt_s = win_next_s;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
          idx_nxt_s   = ZERO;
          cnt_clear_s = 1'b1;
        end
      endcase
    end
  end

  // Output registers and latched configuration.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      acq_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      idx_r  <= ZERO;
      pd_r   <= ZERO;
      ep_r   <= ZERO;
      off_r  <= ZERO;
      len_r  <= ZERO;
      ec_r   <= ZERO;
    end else begin
      acq_r  <= acq_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
      idx_r  <= idx_nxt_s;
      if (latch_s) begin
        pd_r  <= PRE_DELAY;
        ep_r  <= ECHO_PERIOD;
        off_r <= WND_OFFSET;
        len_r <= WND_LENGTH;
        ec_r  <= ECHO_COUNT;
      end else begin
        pd_r  <= pd_r;
        ep_r  <= ep_r;
        off_r <= off_r;
        len_r <= len_r;
        ec_r  <= ec_r;
      end
    end
  end

  assign ACQ_WND  = acq_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign ERR      = err_r;
  assign ECHO_IDX = idx_r;

endmodule

// File: tb/tb_acq_echo_scheduler.sv
// Self-checking bench: directed scenarios plus random trains, every cycle
// compared against an arithmetic model of the echo-train timing.
module tb_acq_echo_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pre_delay = 32'd0;
  logic [31:0] echo_period = 32'd0;
  logic [31:0] wnd_offset = 32'd0;
  logic [31:0] wnd_length = 32'd0;
  logic [31:0] echo_count = 32'd0;
  logic        acq_wnd, busy, done, err;
  logic [31:0] echo_idx;

  int n_checks = 0;
  int n_bad = 0;
  longint unsigned cyc = 0;

  // Model of the most recently accepted START: timing follows from t0 and config.
  bit m_has = 1'b0;
  bit m_valid = 1'b0;
  longint unsigned m_t0, m_pd, m_ep, m_off, m_len, m_ec;

  always #5 clk = ~clk;

  acq_echo_scheduler #(.DATABUS_WIDTH(32)) dut (
    .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
    .PRE_DELAY(pre_delay), .ECHO_PERIOD(echo_period), .WND_OFFSET(wnd_offset),
    .WND_LENGTH(wnd_length), .ECHO_COUNT(echo_count),
    .ACQ_WND(acq_wnd), .BUSY(busy), .DONE(done), .ERR(err), .ECHO_IDX(echo_idx)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit model_idle(input longint unsigned e);
    if (!m_has || !m_valid) return 1'b1;
    return e >= m_t0 + 1 + m_pd + m_ec * m_ep;
  endfunction

  // Expected outputs as seen at edge e.
  task automatic expect_at(input longint unsigned e, output logic e_acq, output logic e_busy,
                           output logic e_done, output logic e_err, output logic [31:0] e_idx);
    longint unsigned p, endt, ph;
    e_acq = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_idx = 32'd0;
    if (m_has && !m_valid) begin
      e_err = (e == m_t0 + 1);
    end else if (m_has) begin
      p = m_t0 + 1 + m_pd;
      endt = p + m_ec * m_ep;
      e_busy = (e >= m_t0 + 1) && (e < endt);
      e_done = (e == endt);
      if (e >= p && e < endt) begin
        e_idx = 32'((e - p) / m_ep);
        ph = (e - p) % m_ep;
        e_acq = (ph >= m_off) && (ph < m_off + m_len);
      end
    end
  endtask

  task automatic tick(input logic st, input logic ab, input logic rs);
    logic x_acq, x_busy, x_done, x_err;
    logic [31:0] x_idx;
    start = st; abort = ab; rst_n = rs;
    @(posedge clk);
    cyc++;
    if (!rs || ab) begin
      m_has = 1'b0;
    end else if (st && model_idle(cyc)) begin
      m_has = 1'b1;
      m_t0 = cyc;
      m_pd = pre_delay; m_ep = echo_period; m_off = wnd_offset;
      m_len = wnd_length; m_ec = echo_count;
      m_valid = (m_ec != 0) && (m_len != 0) && (m_off + m_len < m_ep);
    end
    @(negedge clk);
    expect_at(cyc + 1, x_acq, x_busy, x_done, x_err, x_idx);
    check_val("acq_wnd", {31'd0, acq_wnd}, {31'd0, x_acq});
    check_val("busy", {31'd0, busy}, {31'd0, x_busy});
    check_val("done", {31'd0, done}, {31'd0, x_done});
    check_val("err", {31'd0, err}, {31'd0, x_err});
    check_val("echo_idx", echo_idx, x_idx);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_cfg(input logic [31:0] pd, input logic [31:0] ep, input logic [31:0] off,
                         input logic [31:0] len, input logic [31:0] ec);
    pre_delay = pd; echo_period = ep; wnd_offset = off; wnd_length = len; echo_count = ec;
  endtask

  task automatic rand_cfg();
    echo_period = $urandom_range(12, 2);
    wnd_length  = $urandom_range(echo_period, 0);
    wnd_offset  = $urandom_range(echo_period - 1, 0);
    pre_delay   = $urandom_range(4, 0);
    echo_count  = $urandom_range(4, 0);
    if ($urandom_range(15, 0) == 0) wnd_offset = 32'hFFFF_FFFF;
  endtask

  initial begin
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    run(2);

    // Nominal train, ignored START at t0+30, period change at t0+15.
    set_cfg(32'd5, 32'd20, 32'd4, 32'd10, 32'd3);
    tick(1'b1, 1'b0, 1'b1);
    run(14);
    echo_period = 32'd7;
    run(15);
    tick(1'b1, 1'b0, 1'b1);
    run(40);

    // Zero delays, back-to-back windows.
    set_cfg(32'd0, 32'd4, 32'd0, 32'd3, 32'd2);
    tick(1'b1, 1'b0, 1'b1);
    run(12);

    // Rejected configurations.
    set_cfg(32'd5, 32'd20, 32'd4, 32'd10, 32'd0);
    tick(1'b1, 1'b0, 1'b1);
    run(3);
    set_cfg(32'd5, 32'd20, 32'd10, 32'd10, 32'd3);
    tick(1'b1, 1'b0, 1'b1);
    run(3);
    set_cfg(32'd5, 32'd20, 32'hFFFF_FFFF, 32'd2, 32'd3);
    tick(1'b1, 1'b0, 1'b1);
    run(3);

    // Abort at t0+35, fresh train at t0+40.
    set_cfg(32'd5, 32'd20, 32'd4, 32'd10, 32'd3);
    tick(1'b1, 1'b0, 1'b1);
    run(34);
    tick(1'b0, 1'b1, 1'b1);
    run(4);
    tick(1'b1, 1'b0, 1'b1);
    run(70);

    // START together with ABORT in IDLE.
    tick(1'b1, 1'b1, 1'b1);
    run(5);

    // Reset mid-train at t0+25.
    tick(1'b1, 1'b0, 1'b1);
    run(24);
    tick(1'b0, 1'b0, 1'b0);
    run(5);

    // Random trains with stray STARTs, aborts, resets and config churn.
    for (int t = 0; t < 150; t++) begin
      rand_cfg();
      tick(1'b1, 1'b0, 1'b1);
      for (int g = 0; g < 200 && !model_idle(cyc + 1); g++) begin
        if ($urandom_range(5, 0) == 0) rand_cfg();
        tick(($urandom_range(7, 0) == 0), ($urandom_range(59, 0) == 0),
             ($urandom_range(199, 0) != 0));
      end
      run(2);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
